cdc_handshake_tx: RTL and testbench
===================================

Name: cdc_handshake_tx

Overview:
Source-domain half of a two-phase (toggle) bundled-data clock-domain crossing. It accepts a WIDTH-bit word via a valid/ready handshake and holds the word stable on xfer_data. It signals the word by toggling xfer_req, then waits until the destination's returned acknowledge toggle, synchronized into clk, matches xfer_req. It pairs with the destination-side bit synchronizer/receiver on the far domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
NUM_FLIP_FLOPS, 2, depth of internal ack synchronizer chain (>=2)
COUNT_WIDTH, 16, width of completed-transfer counter

Ports:
clk  input  1  source-domain clock
reset  input  1  asynchronous, active-high reset
s_data  input  WIDTH  word to transfer
s_valid  input  1  s_data valid
s_ready  output  1  block can accept a word; equals (state==IDLE)
xfer_data  output  WIDTH  registered word, stable while transfer outstanding
xfer_req  output  1  request toggle, registered
xfer_ack_async  input  1  ack toggle from destination domain (asynchronous to clk)
busy  output  1  equals (state==WAIT_ACK)
xfer_count  output  COUNT_WIDTH  completed transfers, wraps modulo 2^COUNT_WIDTH
protocol_err  output  1  sticky: ack toggled with no request outstanding

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - state=IDLE, xfer_data=0, xfer_req=0, ack chain all 0, xfer_count=0, protocol_err=0.
  - Hence s_ready=1, busy=0.
- Ack sync: NUM_FLIP_FLOPS-flop shift chain on xfer_ack_async; ack_sync = last flop. Raw xfer_ack_async is never used combinationally.
- IDLE:
  - s_ready=1.
  - On an edge with s_valid=1: xfer_data<=s_data, xfer_req<=~xfer_req, state<=WAIT_ACK.
  - Otherwise everything holds.
- WAIT_ACK:
  - s_ready=0; xfer_data and xfer_req must not change.
  - On an edge where ack_sync==xfer_req: state<=IDLE, xfer_count<=xfer_count+1.
  - s_ready is high in the following cycle.
- Latency:
  - Ack toggle arriving before edge k is seen in ack_sync after edge k+NUM_FLIP_FLOPS-1; state returns to IDLE at edge k+NUM_FLIP_FLOPS.
  - Loopback (ack=req): accept at edge 0, s_ready high after edge NUM_FLIP_FLOPS+1. Max throughput is one word per NUM_FLIP_FLOPS+2 cycles.
- No back-to-back acceptance: the edge that completes WAIT_ACK never also accepts a word.
- protocol_err:
  - Set on any IDLE-state edge where ack_sync!=xfer_req.
  - Cleared only by reset.
  - The state machine ignores the condition and continues normal operation.
- s_data is ignored outside the accepting edge. s_valid may drop without an accept; no data is consumed.
- xfer_count wraps from 2^COUNT_WIDTH-1 to 0 silently.
- Reset mid-transfer:
  - Returns to IDLE with xfer_req=0; any in-flight word is lost.
  - The destination side must be reset in the same event; otherwise phase mismatch is flagged via protocol_err.
- xfer_data and xfer_req come straight from flops (no combinational path to outputs), so they are safe for a max-delay-constrained crossing.

Test Plan:
- Reset release, idle 10 cycles, ack=0 -> s_ready=1, busy=0, xfer_req=0, xfer_data=0x00, xfer_count=0, protocol_err=0 throughout.
- Loopback ack=req, drive s_data=0xA5, s_valid=1 one cycle at edge 0 -> after edge 0: xfer_req=1, xfer_data=0xA5, s_ready=0; after edge 3: s_ready=1, xfer_count=1.
- Loopback, s_valid held high with data 0x01,0x02,0x03 -> each word accepted 4 cycles apart, xfer_req toggles 1,0,1, xfer_count=3, data never changes while busy.
- Delayed ack: accept 0x3C, hold ack=0 for 50 cycles -> busy=1, xfer_data=0x3C stable for all 50; then toggle ack -> IDLE 2 edges later.
- Spurious ack toggle while IDLE -> protocol_err=1 two edges later and stays 1; a following transfer still completes and increments xfer_count.
- Reset asserted mid-WAIT_ACK (asynchronously, between edges) -> outputs return to reset values immediately without waiting for clk; after release, transfer 0x77 completes normally. Separately, with COUNT_WIDTH=2, 5 transfers -> xfer_count=1.

Source files
------------

// File: rtl/cdc_handshake_tx.sv
// Source side of a two-phase bundled-data CDC: holds a word on xfer_data,
// toggles xfer_req and waits for the synchronized ack toggle to match.
module cdc_handshake_tx #(
    parameter int WIDTH          = 8,
    parameter int NUM_FLIP_FLOPS = 2,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [WIDTH-1:0]       xfer_data,
    output logic                   xfer_req,
    input  logic                   xfer_ack_async,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] xfer_count,
    output logic                   protocol_err
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          xfer_data_q, xfer_data_d;
    logic                      xfer_req_q, xfer_req_d;
    logic [NUM_FLIP_FLOPS-1:0] ack_sync_q, ack_sync_d;
    logic [COUNT_WIDTH-1:0]    count_q, count_d;
    logic                      err_q, err_d;
    logic                      ack_sync;

    localparam logic [COUNT_WIDTH-1:0] CountOne = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    assign ack_sync = ack_sync_q[NUM_FLIP_FLOPS-1];

    always_comb begin
        ack_sync_d  = {ack_sync_q[NUM_FLIP_FLOPS-2:0], xfer_ack_async};
        state_d     = state_q;
        xfer_data_d = xfer_data_q;
        xfer_req_d  = xfer_req_q;
        count_d     = count_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                // Phases must agree while idle; a mismatch means a stray ack
                if (ack_sync != xfer_req_q) err_d = 1'b1;
                if (s_valid) begin
                    xfer_data_d = s_data;
                    xfer_req_d  = ~xfer_req_q;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_sync == xfer_req_q) begin
                    state_d = IDLE;
                    count_d = count_q + CountOne;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            xfer_data_q <= '0;
            xfer_req_q  <= 1'b0;
            ack_sync_q  <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            xfer_data_q <= xfer_data_d;
            xfer_req_q  <= xfer_req_d;
            ack_sync_q  <= ack_sync_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    assign s_ready      = (state_q == IDLE);
    assign busy         = (state_q == WAIT_ACK);
    assign xfer_data    = xfer_data_q;
    assign xfer_req     = xfer_req_q;
    assign xfer_count   = count_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx: loopback, delayed ack, stray ack,
// async reset mid-transfer and counter wrap on a narrow-counter instance.
module tb_cdc_handshake_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  xfer_data;
    logic        xfer_req;
    logic        ack_in;
    logic        busy;
    logic [15:0] xfer_count;
    logic        protocol_err;

    logic        loopback;
    logic        ack_man;

    logic        s_valid2;
    logic        s_ready2;
    logic [7:0]  xfer_data2;
    logic        xfer_req2;
    logic        busy2;
    logic [1:0]  xfer_count2;
    logic        protocol_err2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign ack_in = loopback ? xfer_req : ack_man;

    cdc_handshake_tx #(.WIDTH(8), .NUM_FLIP_FLOPS(2), .COUNT_WIDTH(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .xfer_data      (xfer_data),
        .xfer_req       (xfer_req),
        .xfer_ack_async (ack_in),
        .busy           (busy),
        .xfer_count     (xfer_count),
        .protocol_err   (protocol_err)
    );

    cdc_handshake_tx #(.WIDTH(8), .NUM_FLIP_FLOPS(2), .COUNT_WIDTH(2)) dut2 (
        .clk            (clk),
        .reset          (reset),
        .s_data         (8'h11),
        .s_valid        (s_valid2),
        .s_ready        (s_ready2),
        .xfer_data      (xfer_data2),
        .xfer_req       (xfer_req2),
        .xfer_ack_async (xfer_req2),
        .busy           (busy2),
        .xfer_count     (xfer_count2),
        .protocol_err   (protocol_err2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] words [3];

    initial begin
        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;
        reset    = 1'b1;
        s_data   = 8'h00;
        s_valid  = 1'b0;
        s_valid2 = 1'b0;
        loopback = 1'b0;
        ack_man  = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ready", s_ready, 1);
            check("idle_busy", busy, 0);
            check("idle_req", xfer_req, 0);
            check("idle_data", xfer_data, 8'h00);
            check("idle_count", xfer_count, 0);
            check("idle_err", protocol_err, 0);
        end

        // Single loopback transfer
        loopback = 1'b1;
        s_data   = 8'hA5;
        s_valid  = 1'b1;
        tick();
        s_valid = 1'b0;
        check("lb_req", xfer_req, 1);
        check("lb_data", xfer_data, 8'hA5);
        check("lb_ready0", s_ready, 0);
        tick();
        check("lb_ready1", s_ready, 0);
        tick();
        check("lb_ready2", s_ready, 0);
        tick();
        check("lb_ready3", s_ready, 1);
        check("lb_count", xfer_count, 1);

        // Streaming with s_valid held; req goes 0,1,0
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = words[i];
            tick();
            check("st_req", xfer_req, (i % 2 == 0) ? 0 : 1);
            check("st_data", xfer_data, words[i]);
            check("st_busy", busy, 1);
            s_data = 8'hFF;
            tick();
            check("st_hold1", xfer_data, words[i]);
            tick();
            check("st_hold2", xfer_data, words[i]);
            check("st_busy2", busy, 1);
            tick();
            check("st_ready", s_ready, 1);
            check("st_count", xfer_count, 2 + i);
        end
        s_valid = 1'b0;

        // Delayed ack
        loopback = 1'b0;
        ack_man  = 1'b0;
        s_data   = 8'h3C;
        s_valid  = 1'b1;
        tick();
        s_valid = 1'b0;
        s_data  = 8'h00;
        check("dl_req", xfer_req, 1);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("dl_busy", busy, 1);
            check("dl_data", xfer_data, 8'h3C);
        end
        ack_man = 1'b1;
        tick();
        check("dl_busy_k", busy, 1);
        tick();
        check("dl_busy_k1", busy, 1);
        tick();
        check("dl_ready", s_ready, 1);
        check("dl_count", xfer_count, 5);
        check("dl_err", protocol_err, 0);

        // Stray ack toggle while idle
        ack_man = 1'b0;
        tick();
        check("sp_err_k", protocol_err, 0);
        tick();
        check("sp_err_k1", protocol_err, 0);
        tick();
        check("sp_err_k2", protocol_err, 1);
        s_data  = 8'h5A;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("sp_req", xfer_req, 0);
        check("sp_busy", busy, 1);
        tick();
        check("sp_ready", s_ready, 1);
        check("sp_count", xfer_count, 6);
        check("sp_err_sticky", protocol_err, 1);

        // Async reset in the middle of WAIT_ACK
        s_data  = 8'hC3;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("rs_busy", busy, 1);
        check("rs_req", xfer_req, 1);
        tick();
        #3;
        reset = 1'b1;
        #1;
        check("rs_ready", s_ready, 1);
        check("rs_busy0", busy, 0);
        check("rs_req0", xfer_req, 0);
        check("rs_data0", xfer_data, 8'h00);
        check("rs_count0", xfer_count, 0);
        check("rs_err0", protocol_err, 0);
        ack_man = 1'b0;
        tick();
        reset    = 1'b0;
        loopback = 1'b1;
        s_data   = 8'h77;
        s_valid  = 1'b1;
        tick();
        s_valid = 1'b0;
        check("rs_req1", xfer_req, 1);
        check("rs_data1", xfer_data, 8'h77);
        repeat (3) tick();
        check("rs_ready1", s_ready, 1);
        check("rs_count1", xfer_count, 1);
        check("rs_err1", protocol_err, 0);

        // 2-bit counter wraps after 4 transfers
        for (int i = 0; i < 5; i++) begin
            s_valid2 = 1'b1;
            tick();
            s_valid2 = 1'b0;
            check("wr_busy", busy2, 1);
            repeat (3) tick();
            check("wr_ready", s_ready2, 1);
        end
        check("wr_count", xfer_count2, 1);
        check("wr_err", protocol_err2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
